// File: rtl/etroc_frame_builder_pkg.sv
// Shared constants for the ETROC frame builder: frame markers, FSM state encoding,
// trailer status bit positions and the CRC-8 polynomial.
package etroc_frame_builder_pkg;

    localparam logic [15:0] FRAME_MARKER = 16'h3C5C;
    localparam logic [1:0]  TYPE_HEADER  = 2'b00;
    localparam logic [1:0]  TYPE_FILLER  = 2'b10;
    localparam logic [39:0] FILLER_FRAME = {FRAME_MARKER, TYPE_FILLER, 22'h000000};

    localparam int ST_TRUNC = 0;
    localparam int ST_EMPTY = 1;

    localparam logic [7:0] CRC_POLY = 8'h2F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HITS    = 2'd1,
        S_DRAIN   = 2'd2,
        S_TRAILER = 2'd3
    } state_t;

endpackage

// File: rtl/etroc_frame_builder_frame_crc8.sv
// Combinational CRC-8 step over one W-bit frame, MSB first, no reflection.
module etroc_frame_builder_frame_crc8
    import etroc_frame_builder_pkg::*;
#(
    parameter int W = 40
) (
    input  logic [7:0]   crc_in,
    input  logic [W-1:0] data,
    output logic [7:0]   crc_out
);

    logic [7:0] crc_s;

    // Serial shift-register CRC unrolled across the whole frame.
    always_comb begin
        crc_s = crc_in;
        for (int i = W - 1; i >= 0; i--) begin
            if (crc_s[7] ^ data[i]) begin
                crc_s = {crc_s[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_s = {crc_s[6:0], 1'b0};
            end
        end
    end

    assign crc_out = crc_s;

endmodule

// File: rtl/etroc_frame_builder.sv
// ETROC frame builder: header / hit / trailer / filler frame sequencer with back-pressure.
// Optional trailer CRC-8 enabled by defining FRAME_CRC_EN.
module etroc_frame_builder
    import etroc_frame_builder_pkg::*;
#(
    parameter int MAXHITS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] chip_id,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [11:0] evt_bcid,
    input  logic [7:0]  evt_l1cnt,
    input  logic [1:0]  evt_type,
    input  logic        evt_nohit,
    input  logic        hit_valid,
    output logic        hit_ready,
    input  logic [38:0] hit_data,
    input  logic        hit_last,
    input  logic        almost_full,
    output logic [39:0] data_frame,
    output logic        busy
);

    localparam logic [7:0] MAXHITS_W = 8'(MAXHITS);

    state_t      state_q, state_d;
    logic [39:0] frame_q, frame_d;
    logic [7:0]  nhits_q, nhits_d;
    logic [5:0]  status_q, status_d;

    logic        evt_acc_s, hit_acc_s;
    logic [39:0] header_s, hit_s;
    logic [31:0] trailer_body_s;
    logic [7:0]  crc_field_s;

    // Ready is held low while reset is asserted; DRAIN absorbs hits regardless of back-pressure.
    assign evt_ready = reset & (state_q == S_IDLE) & ~almost_full;
    assign hit_ready = reset & (((state_q == S_HITS) & ~almost_full) | (state_q == S_DRAIN));
    assign evt_acc_s = evt_valid & evt_ready;
    assign hit_acc_s = hit_valid & hit_ready;

    assign header_s       = {FRAME_MARKER, TYPE_HEADER, evt_l1cnt, evt_type, evt_bcid};
    assign hit_s          = {1'b1, hit_data};
    assign trailer_body_s = {1'b0, chip_id, status_q, nhits_q};

`ifdef FRAME_CRC_EN
    logic [7:0] crc_q, crc_d, crc_hdr_s, crc_hit_s;

    etroc_frame_builder_frame_crc8 #(.W(40)) u_crc_hdr (
        .crc_in (8'h00),
        .data   (header_s),
        .crc_out(crc_hdr_s)
    );

    etroc_frame_builder_frame_crc8 #(.W(40)) u_crc_hit (
        .crc_in (crc_q),
        .data   (hit_s),
        .crc_out(crc_hit_s)
    );

    etroc_frame_builder_frame_crc8 #(.W(32)) u_crc_trl (
        .crc_in (crc_q),
        .data   (trailer_body_s),
        .crc_out(crc_field_s)
    );

    // Accumulator restarts on each header and extends only over hits actually emitted.
    always_comb begin
        if (evt_acc_s) begin
            crc_d = crc_hdr_s;
        end else if ((state_q == S_HITS) && hit_acc_s) begin
            crc_d = crc_hit_s;
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC accumulator register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign crc_field_s = 8'h00;
`endif

    // Next-state and next-frame selection; filler unless a real frame goes out this cycle.
    always_comb begin
        state_d  = state_q;
        frame_d  = FILLER_FRAME;
        nhits_d  = nhits_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (evt_acc_s) begin
                    frame_d            = header_s;
                    nhits_d            = 8'd0;
                    status_d           = 6'b000000;
                    status_d[ST_EMPTY] = evt_nohit;
                    state_d            = evt_nohit ? S_TRAILER : S_HITS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HITS: begin
                if (hit_acc_s) begin
                    frame_d = hit_s;
                    nhits_d = nhits_q + 8'd1;
                    if (hit_last) begin
                        state_d = S_TRAILER;
                    end else if ((nhits_q + 8'd1) == MAXHITS_W) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_HITS;
                    end
                end else begin
                    state_d = S_HITS;
                end
            end
            S_DRAIN: begin
                if (hit_acc_s) begin
                    status_d[ST_TRUNC] = 1'b1;
                    state_d            = hit_last ? S_TRAILER : S_DRAIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_TRAILER: begin
                if (!almost_full) begin
                    frame_d = {trailer_body_s, crc_field_s};
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TRAILER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, output frame and trailer bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            frame_q  <= FILLER_FRAME;
            nhits_q  <= 8'd0;
            status_q <= 6'b000000;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            nhits_q  <= nhits_d;
            status_q <= status_d;
        end
    end

    assign data_frame = frame_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_etroc_frame_builder.sv
// Self-checking bench for etroc_frame_builder: directed scenarios plus randomized events
// checked against an event-level reference model (expected frame queue, CRC by polynomial division).
module tb_etroc_frame_builder;

    localparam int MAXH = 4;
    localparam int LIM  = 100;
    localparam logic [39:0] FILLER = {16'h3C5C, 2'b10, 22'h000000};

    logic        clk;
    logic        reset;
    logic [16:0] chip_id;
    logic        evt_valid, evt_ready, evt_nohit;
    logic [11:0] evt_bcid;
    logic [7:0]  evt_l1cnt;
    logic [1:0]  evt_type;
    logic        hit_valid, hit_ready, hit_last;
    logic [38:0] hit_data;
    logic        almost_full;
    logic [39:0] data_frame;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [39:0] exp_q[$];
    logic [39:0] trace[$];
    logic [38:0] cur_hits[$];
    logic        mon_en = 1'b0;
    logic        af_seen = 1'b0;
    logic        rst_seen = 1'b0;

    etroc_frame_builder #(.MAXHITS(MAXH)) dut (
        .clk(clk), .reset(reset), .chip_id(chip_id),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_bcid(evt_bcid),
        .evt_l1cnt(evt_l1cnt), .evt_type(evt_type), .evt_nohit(evt_nohit),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_data(hit_data),
        .hit_last(hit_last), .almost_full(almost_full),
        .data_frame(data_frame), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_f(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cls(input logic [39:0] f);
        if (f === FILLER) return "F";
        if (f[39:22] === {16'h3C5C, 2'b00}) return "H";
        if (f[39] === 1'b1) return "D";
        return "T";
    endfunction

    // CRC-8 (0x2F) as remainder of the message times x^8 divided by the generator.
    function automatic logic [7:0] crc_div(input bit msg[$]);
        logic [7:0] r = 8'h00;
        logic top;
        for (int i = 0; i < msg.size() + 8; i++) begin
            top = r[7];
            r = {r[6:0], (i < msg.size()) ? msg[i] : 1'b0};
            if (top) r = r ^ 8'h2F;
        end
        return r;
    endfunction

    // Expected frames of one event: header, up to MAXH hits, trailer.
    task automatic model_event(input logic [11:0] bcid, input logic [7:0] l1,
                               input logic [1:0] typ, input logic nohit);
        bit msg[$];
        logic [39:0] f;
        logic [31:0] body;
        logic [7:0]  crc;
        int n, emit;
        f = {16'h3C5C, 2'b00, l1, typ, bcid};
        exp_q.push_back(f);
        for (int b = 39; b >= 0; b--) msg.push_back(f[b]);
        n = nohit ? 0 : cur_hits.size();
        emit = (n > MAXH) ? MAXH : n;
        for (int i = 0; i < emit; i++) begin
            f = {1'b1, cur_hits[i]};
            exp_q.push_back(f);
            for (int b = 39; b >= 0; b--) msg.push_back(f[b]);
        end
        body = {1'b0, chip_id, 4'b0000, nohit, (n > MAXH), 8'(emit)};
        for (int b = 31; b >= 0; b--) msg.push_back(body[b]);
`ifdef FRAME_CRC_EN
        crc = crc_div(msg);
`else
        crc = 8'h00;
`endif
        exp_q.push_back({body, crc});
    endtask

    // Every frame after an edge with reset low or almost_full high must be filler;
    // otherwise every non-filler frame must be the next expected one.
    always @(posedge clk) begin
        af_seen  = almost_full;
        rst_seen = reset;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            trace.push_back(data_frame);
            if (!rst_seen || af_seen) begin
                check_f("blocked_filler", data_frame, FILLER);
            end else if (data_frame !== FILLER) begin
                if (exp_q.size() == 0) check_f("unexpected_frame", data_frame, FILLER);
                else check_f("frame", data_frame, exp_q.pop_front());
            end
        end
    end

    function automatic logic af_rand(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic idle(input int af_pct);
        hit_valid   = 1'b0;
        hit_last    = 1'b0;
        almost_full = af_rand(af_pct);
        @(negedge clk);
    endtask

    task automatic hs_evt(input int af_pct);
        logic acc = 1'b0;
        evt_valid = 1'b1;
        for (int t = 0; t < LIM && !acc; t++) begin
            almost_full = af_rand(af_pct);
            #1 acc = evt_ready;
            @(negedge clk);
        end
        evt_valid = 1'b0;
        check_i("evt_handshake", int'(acc), 1);
    endtask

    task automatic hs_hit(input logic [38:0] d, input logic last, input int af_pct);
        logic acc = 1'b0;
        hit_valid = 1'b1;
        hit_data  = d;
        hit_last  = last;
        for (int t = 0; t < LIM && !acc; t++) begin
            almost_full = af_rand(af_pct);
            #1 acc = hit_ready;
            @(negedge clk);
        end
        hit_valid = 1'b0;
        hit_last  = 1'b0;
        check_i("hit_handshake", int'(acc), 1);
    endtask

    task automatic wait_done(input int af_pct);
        for (int t = 0; t < LIM && exp_q.size() != 0; t++) begin
            almost_full = af_rand(af_pct);
            @(negedge clk);
        end
        almost_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_i("event_complete", exp_q.size(), 0);
    endtask

    task automatic gen_hits(input int nh);
        logic [63:0] r;
        cur_hits.delete();
        for (int i = 0; i < nh; i++) begin
            r = {$urandom, $urandom};
            cur_hits.push_back(r[38:0]);
        end
    endtask

    task automatic send_event(input logic [11:0] bcid, input logic [7:0] l1, input logic [1:0] typ,
                              input logic nohit, input int nh, input int gap_idx, input int gap_len,
                              input int gap_pct, input int af_pct);
        gen_hits(nh);
        model_event(bcid, l1, typ, nohit);
        trace.delete();
        evt_bcid  = bcid;
        evt_l1cnt = l1;
        evt_type  = typ;
        evt_nohit = nohit;
        hs_evt(af_pct);
        if (!nohit) begin
            for (int i = 0; i < nh; i++) begin
                for (int g = 0; g < ((i == gap_idx) ? gap_len : 0); g++) idle(af_pct);
                for (int g = 0; g < 4 && af_rand(gap_pct); g++) idle(af_pct);
                hs_hit(cur_hits[i], (i == nh - 1), af_pct);
            end
        end
        wait_done(af_pct);
    endtask

    function automatic int find_hdr();
        for (int i = 0; i < trace.size(); i++) if (cls(trace[i]) == "H") return i;
        return -1;
    endfunction

    function automatic logic [39:0] frame_at(input int k);
        if (k >= 0 && k < trace.size()) return trace[k];
        return 40'h0;
    endfunction

    task automatic check_pattern(input string tag, input string p);
        int h = find_hdr();
        check_i({tag, "_hdr_found"}, int'(h >= 0), 1);
        for (int i = 0; i < p.len(); i++) begin
            check_i({tag, "_class"}, int'(cls(frame_at(h + i))), int'(p[i]));
        end
    endtask

    initial begin
        logic [39:0] f;
        int h;
        reset = 1'b0; chip_id = 17'h1A5B3;
        evt_valid = 1'b0; evt_bcid = 12'h000; evt_l1cnt = 8'h00; evt_type = 2'b00; evt_nohit = 1'b0;
        hit_valid = 1'b0; hit_data = 39'h0; hit_last = 1'b0; almost_full = 1'b0;

        // Reset held three clocks, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_f("rst_frame", data_frame, FILLER);
        check_i("rst_evt_ready", int'(evt_ready), 0);
        check_i("rst_hit_ready", int'(hit_ready), 0);
        check_i("rst_busy", int'(busy), 0);
        reset = 1'b1;
        mon_en = 1'b1;
        #1 check_i("rel_evt_ready", int'(evt_ready), 1);
        @(negedge clk);
        check_f("rel_frame", data_frame, 40'h3C5C800000);
        check_i("rel_busy", int'(busy), 0);

        // Empty event: header, trailer, filler.
        send_event(12'h123, 8'h45, 2'b01, 1'b1, 0, -1, 0, 0, 0);
        check_pattern("nohit", "HTF");
        h = find_hdr();
        check_f("nohit_header", frame_at(h), {16'h3C5C, 2'b00, 8'h45, 2'b01, 12'h123});
        f = frame_at(h + 1);
        check_i("nohit_nhits", int'(f[15:8]), 0);
        check_i("nohit_status", int'(f[21:16]), 2);
`ifndef FRAME_CRC_EN
        check_i("nohit_crc_zero", int'(f[7:0]), 0);
`endif

        // Three hits with a two-cycle gap before the second.
        send_event(12'h0AA, 8'h01, 2'b10, 1'b0, 3, 1, 2, 0, 0);
        check_pattern("gap", "HDFFDDT");
        f = frame_at(find_hdr() + 6);
        check_i("gap_nhits", int'(f[15:8]), 3);

        // Six hits against MAXH=4: two absorbed, truncated flag set.
        send_event(12'hFFF, 8'hFF, 2'b11, 1'b0, 6, -1, 0, 0, 0);
        check_pattern("trunc", "HDDDDFFT");
        f = frame_at(find_hdr() + 7);
        check_i("trunc_nhits", int'(f[15:8]), 4);
        check_i("trunc_status", int'(f[21:16]), 1);

        // Last hit exactly at MAXH: no truncation.
        send_event(12'h800, 8'h80, 2'b00, 1'b0, 4, -1, 0, 0, 0);
        check_pattern("exact", "HDDDDT");
        f = frame_at(find_hdr() + 5);
        check_i("exact_nhits", int'(f[15:8]), 4);
        check_i("exact_status", int'(f[21:16]), 0);

        // Back-pressure for five clocks in HITS and in TRAILER.
        gen_hits(3);
        model_event(12'h555, 8'h10, 2'b01, 1'b0);
        evt_bcid = 12'h555; evt_l1cnt = 8'h10; evt_type = 2'b01; evt_nohit = 1'b0;
        hs_evt(0);
        almost_full = 1'b1; hit_valid = 1'b1; hit_data = cur_hits[0]; hit_last = 1'b0;
        repeat (5) begin
            #1 check_i("af_hit_ready", int'(hit_ready), 0);
            @(negedge clk);
        end
        almost_full = 1'b0;
        #1 check_i("af_hit_ready_resume", int'(hit_ready), 1);
        @(negedge clk);
        check_i("af_resume_hit", int'(cls(data_frame)), int'("D"));
        hs_hit(cur_hits[1], 1'b0, 0);
        hs_hit(cur_hits[2], 1'b1, 0);
        almost_full = 1'b1;
        repeat (5) begin
            #1 check_i("af_trailer_busy", int'(busy), 1);
            @(negedge clk);
        end
        almost_full = 1'b0;
        @(negedge clk);
        check_i("af_resume_trailer", int'(cls(data_frame)), int'("T"));
        wait_done(0);

        // Randomized events under random gaps and back-pressure.
        for (int e = 0; e < 20; e++) begin
            send_event(12'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                       $urandom_range(1, 7), -1, 0, 30, 25);
        end

        // Reset in the middle of HITS abandons the event.
        gen_hits(4);
        model_event(12'h321, 8'h22, 2'b10, 1'b0);
        evt_bcid = 12'h321; evt_l1cnt = 8'h22; evt_type = 2'b10; evt_nohit = 1'b0;
        hs_evt(0);
        hs_hit(cur_hits[0], 1'b0, 0);
        hs_hit(cur_hits[1], 1'b0, 0);
        reset = 1'b0; hit_valid = 1'b1; hit_data = cur_hits[2];
        @(negedge clk);
        check_f("midrst_frame", data_frame, FILLER);
        check_i("midrst_busy", int'(busy), 0);
        check_i("midrst_hit_ready", int'(hit_ready), 0);
        check_i("midrst_evt_ready", int'(evt_ready), 0);
        exp_q.delete();
        reset = 1'b1; hit_valid = 1'b0;
        #1 check_i("midrst_idle_ready", int'(evt_ready), 1);
        @(negedge clk);
        check_i("midrst_idle_busy", int'(busy), 0);
        check_i("midrst_no_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
